// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: an instruction fetch port and a data load/store port
// share one memory port with one transaction outstanding. Data has priority, with bounded fetch starvation.
module mem_port_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int AW         = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ready,
   output logic [31:0]   if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [1:0]    d_dw,
   input  logic          d_sext,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_ready,
   output logic          d_err,
   output logic [31:0]   d_rdata,
   output logic          m_req,
   output logic          m_we,
   output logic [3:0]    m_be,
   output logic [AW-1:0] m_addr,
   output logic [31:0]   m_wdata,
   input  logic          m_ack,
   input  logic [31:0]   m_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_I = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;
   localparam logic [1:0] ERR_D  = 2'd3;

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [1:0]    state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          m_req_q, m_req_d;
   logic          m_we_q, m_we_d;
   logic [3:0]    m_be_q, m_be_d;
   logic [AW-1:0] m_addr_q, m_addr_d;
   logic [31:0]   m_wdata_q, m_wdata_d;
   logic [1:0]    ld_off_q, ld_off_d;
   logic [1:0]    ld_dw_q, ld_dw_d;
   logic          ld_sext_q, ld_sext_d;

   logic [1:0]    d_off;
   logic          d_misalign;
   logic [3:0]    d_be;
   logic [31:0]   st_wdata;
   logic          arb_en;
   logic          grant_d;
   logic          grant_i;
   logic [31:0]   ld_word;
   logic [31:0]   ld_ext;
   logic          if_addr_unused;

   // Fetch addresses are word aligned by contract; the low bits are dropped.
   assign if_addr_unused = ^if_addr[1:0];

   assign d_off      = d_addr[1:0];
   assign d_misalign = (d_dw == 2'd3) || (d_dw == 2'd1 && d_off[0]) ||
                       (d_dw == 2'd2 && d_off != 2'd0);

   always_comb begin
      case (d_dw)
         2'd0:    d_be = 4'b0001 << d_off;
         2'd1:    d_be = d_off[1] ? 4'b1100 : 4'b0011;
         default: d_be = 4'b1111;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign st_wdata[8*gi +: 8] = (d_dw == 2'd0) ? d_wdata[7:0] :
                                      (d_dw == 2'd1) ? d_wdata[8*(gi%2) +: 8] :
                                                       d_wdata[8*gi +: 8];
      end
   endgenerate

   // The completing cycle of a memory transaction is also an arbitration slot.
   assign arb_en  = (state_q == IDLE) ||
                    ((state_q == BUSY_I || state_q == BUSY_D) && m_ack);
   assign grant_d = arb_en && d_req && !(if_req && starve_q == STARVE_LIM);
   assign grant_i = arb_en && if_req && !grant_d;

   always_comb begin
      state_d   = state_q;
      starve_d  = starve_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_be_d    = m_be_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      ld_off_d  = ld_off_q;
      ld_dw_d   = ld_dw_q;
      ld_sext_d = ld_sext_q;
      if (grant_d) begin
         ld_off_d  = d_off;
         ld_dw_d   = d_dw;
         ld_sext_d = d_sext;
         if (d_misalign) begin
            state_d = ERR_D;
            m_req_d = 1'b0;
         end else begin
            state_d   = BUSY_D;
            m_req_d   = 1'b1;
            m_we_d    = d_we;
            m_be_d    = d_be;
            m_addr_d  = {d_addr[AW-1:2], 2'b00};
            m_wdata_d = st_wdata;
         end
      end else if (grant_i) begin
         state_d   = BUSY_I;
         m_req_d   = 1'b1;
         m_we_d    = 1'b0;
         m_be_d    = 4'b1111;
         m_addr_d  = {if_addr[AW-1:2], 2'b00};
         m_wdata_d = 32'h0;
      end else if (arb_en || state_q == ERR_D) begin
         state_d = IDLE;
         m_req_d = 1'b0;
      end
      if (!if_req || grant_i) begin
         starve_d = '0;
      end else if (grant_d && starve_q != STARVE_LIM) begin
         starve_d = starve_q + SW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         starve_q  <= '0;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_be_q    <= 4'b0000;
         m_addr_q  <= '0;
         m_wdata_q <= 32'h0;
         ld_off_q  <= 2'd0;
         ld_dw_q   <= 2'd0;
         ld_sext_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_be_q    <= m_be_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         ld_off_q  <= ld_off_d;
         ld_dw_q   <= ld_dw_d;
         ld_sext_q <= ld_sext_d;
      end
   end

   // Load alignment uses the offset/width captured at grant, not the live request.
   assign ld_word = m_rdata >> {ld_off_q, 3'b000};

   always_comb begin
      case (ld_dw_q)
         2'd0:    ld_ext = {{24{ld_sext_q & ld_word[7]}}, ld_word[7:0]};
         2'd1:    ld_ext = {{16{ld_sext_q & ld_word[15]}}, ld_word[15:0]};
         default: ld_ext = m_rdata;
      endcase
   end

   assign if_ready = m_ack && (state_q == BUSY_I);
   assign if_rdata = m_rdata;
   assign d_ready  = (m_ack && state_q == BUSY_D) || (state_q == ERR_D);
   assign d_err    = (state_q == ERR_D);
   assign d_rdata  = (state_q == ERR_D) ? 32'h0 : ld_ext;

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_be    = m_be_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;

endmodule
